// File: rtl/bt_cmd_parser.sv
// Parses "#<letter><hex><hex><CR|LF>" command frames from a UART byte stream.
// Emits a one-cycle cmd_valid or frame_err pulse per frame and keeps good/error counters.
module bt_cmd_parser #(
  parameter logic [19:0] TIMEOUT_CYC = 20'd500000,
  parameter logic [7:0]  START_CHR   = 8'h23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic [7:0] cmd_arg,
  output logic       frame_err,
  output logic [7:0] frame_cnt,
  output logic [7:0] err_cnt,
  output logic       busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CMD    = 3'd1;
  localparam logic [2:0] S_HEX_HI = 3'd2;
  localparam logic [2:0] S_HEX_LO = 3'd3;
  localparam logic [2:0] S_TERM   = 3'd4;

  localparam logic [19:0] TMO_LAST = TIMEOUT_CYC - 20'd1;

  function automatic logic is_letter(input logic [7:0] b);
    return (b >= 8'h41) && (b <= 8'h5A);
  endfunction

  function automatic logic is_hex(input logic [7:0] b);
    return ((b >= 8'h30) && (b <= 8'h39)) ||
           ((b >= 8'h41) && (b <= 8'h46)) ||
           ((b >= 8'h61) && (b <= 8'h66));
  endfunction

  function automatic logic is_term(input logic [7:0] b);
    return (b == 8'h0A) || (b == 8'h0D);
  endfunction

  // Letters 'A'-'F' and 'a'-'f' share the low nibble 1..6, so +9 maps them to 10..15.
  function automatic logic [3:0] hex_val(input logic [7:0] b);
    if (b <= 8'h39) return b[3:0];
    else            return b[3:0] + 4'd9;
  endfunction

  // Reset asserts asynchronously and is released two clk edges after rst rises.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync_q <= 2'b00;
    else      rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  logic [2:0]  state_q, state_d;
  logic [19:0] tmo_q, tmo_d;
  logic [7:0]  code_tmp_q, code_tmp_d;
  logic [3:0]  hi_tmp_q, hi_tmp_d;
  logic [3:0]  lo_tmp_q, lo_tmp_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic        frame_err_q, frame_err_d;
  logic [7:0]  cmd_code_q, cmd_code_d;
  logic [7:0]  cmd_arg_q, cmd_arg_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  always_comb begin
    state_d     = state_q;
    code_tmp_d  = code_tmp_q;
    hi_tmp_d    = hi_tmp_q;
    lo_tmp_d    = lo_tmp_q;
    cmd_code_d  = cmd_code_q;
    cmd_arg_d   = cmd_arg_q;
    cmd_valid_d = 1'b0;
    frame_err_d = 1'b0;
    tmo_d       = (rx_valid || (state_q == S_IDLE)) ? 20'd0 : tmo_q + 20'd1;

    if (rx_valid) begin
      if (state_q == S_IDLE) begin
        if (rx_data == START_CHR) state_d = S_CMD;
      end else if (rx_data == START_CHR) begin
        frame_err_d = 1'b1;
        state_d     = S_CMD;
      end else begin
        case (state_q)
          S_CMD: begin
            if (is_letter(rx_data)) begin
              code_tmp_d = rx_data;
              state_d    = S_HEX_HI;
            end else begin
              frame_err_d = 1'b1;
              state_d     = S_IDLE;
            end
          end
          S_HEX_HI: begin
            if (is_hex(rx_data)) begin
              hi_tmp_d = hex_val(rx_data);
              state_d  = S_HEX_LO;
            end else begin
              frame_err_d = 1'b1;
              state_d     = S_IDLE;
            end
          end
          S_HEX_LO: begin
            if (is_hex(rx_data)) begin
              lo_tmp_d = hex_val(rx_data);
              state_d  = S_TERM;
            end else begin
              frame_err_d = 1'b1;
              state_d     = S_IDLE;
            end
          end
          S_TERM: begin
            if (is_term(rx_data)) begin
              cmd_valid_d = 1'b1;
              cmd_code_d  = code_tmp_q;
              cmd_arg_d   = {hi_tmp_q, lo_tmp_q};
            end else begin
              frame_err_d = 1'b1;
            end
            state_d = S_IDLE;
          end
          default: begin
            frame_err_d = 1'b1;
            state_d     = S_IDLE;
          end
        endcase
      end
    end else if ((state_q != S_IDLE) && (tmo_q == TMO_LAST)) begin
      frame_err_d = 1'b1;
      state_d     = S_IDLE;
    end

    frame_cnt_d = frame_cnt_q + {7'd0, cmd_valid_d};
    err_cnt_d   = (frame_err_d && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tmo_q       <= 20'd0;
      code_tmp_q  <= 8'h00;
      hi_tmp_q    <= 4'h0;
      lo_tmp_q    <= 4'h0;
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      cmd_code_q  <= 8'h00;
      cmd_arg_q   <= 8'h00;
      frame_cnt_q <= 8'h00;
      err_cnt_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      code_tmp_q  <= code_tmp_d;
      hi_tmp_q    <= hi_tmp_d;
      lo_tmp_q    <= lo_tmp_d;
      cmd_valid_q <= cmd_valid_d;
      frame_err_q <= frame_err_d;
      cmd_code_q  <= cmd_code_d;
      cmd_arg_q   <= cmd_arg_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign frame_err = frame_err_q;
  assign cmd_code  = cmd_code_q;
  assign cmd_arg   = cmd_arg_q;
  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign busy      = (state_q != S_IDLE);

endmodule
